// File: rtl/fft_butterfly_sched.sv
// fft_butterfly_sched: radix-2 DIT FFT sequencer feeding an external
// complex butterfly MAC; bit-reversed load, in-place compute, natural unload.
module fft_butterfly_sched #(
    parameter int N    = 8,
    parameter int Q    = 6,
    parameter int LOGP = 3
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] in_data,
    output logic [2*N-1:0] mac_in1,
    output logic [2*N-1:0] mac_in2,
    output logic [2*N-1:0] mac_in3,
    input  logic [2*N-1:0] mac_add,
    input  logic [2*N-1:0] mac_sub,
    input  logic           mac_ovf,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] out_data,
    output logic           ovf_flag,
    output logic           busy
);
    localparam int P   = 1 << LOGP;
    localparam int SW  = $clog2(LOGP + 1);
    localparam int ONE = 1 << Q;
    localparam int RH  = (ONE * 46341 + 32768) >>> 16;

    typedef logic [LOGP-1:0] idx_t;
    typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

    // Sign-magnitude component; zero is always +0.
    function automatic logic [N-1:0] sm(logic neg, int mag);
        return {neg && (mag != 0), (N-1)'(mag)};
    endfunction

    function automatic idx_t bitrev(idx_t v);
        idx_t r;
        for (int i = 0; i < LOGP; i++) r[i] = v[LOGP-1-i];
        return r;
    endfunction

    localparam logic [2*N-1:0] W0 = {sm(1'b0, ONE), sm(1'b0, 0)};
    localparam logic [2*N-1:0] W1 = {sm(1'b0, RH), sm(1'b1, RH)};
    localparam logic [2*N-1:0] W2 = {sm(1'b0, 0), sm(1'b1, ONE)};
    localparam logic [2*N-1:0] W3 = {sm(1'b1, RH), sm(1'b1, RH)};

    state_t          state, state_n;
    idx_t            cnt, ocnt, b;
    logic [SW-1:0]   s;
    idx_t            half, pos, top, bot;
    logic [1:0]      k8;
    logic [2*N-1:0]  twid;
    logic [2*N-1:0]  mem [P];
    logic            last_b, last_s;
    logic            ld_fire, out_fire, cmp_en;

    assign last_b   = (b == idx_t'(P/2 - 1));
    assign last_s   = (s == SW'(LOGP - 1));
    assign ld_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign cmp_en   = (state == COMPUTE) && !rst;

    always_comb begin
        half = idx_t'(1) << s;
        pos  = b & (half - idx_t'(1));
        top  = ((b >> s) << (s + SW'(1))) + pos;
        bot  = top + half;
        k8   = 2'({2'b00, pos} << (3'd2 - 3'(s)));
    end

    always_comb begin
        unique case (k8)
            2'd0: twid = W0;
            2'd1: twid = W1;
            2'd2: twid = W2;
            2'd3: twid = W3;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= LOAD;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        mac_in1   = '0;
        mac_in2   = '0;
        mac_in3   = '0;
        out_data  = '0;
        if (!rst) begin
            unique case (state)
                LOAD: begin
                    in_ready = 1'b1;
                    if (in_valid && cnt == idx_t'(P - 1)) state_n = COMPUTE;
                end
                COMPUTE: begin
                    busy    = 1'b1;
                    mac_in1 = mem[top];
                    mac_in2 = mem[bot];
                    mac_in3 = twid;
                    if (last_b && last_s) state_n = UNLOAD;
                end
                UNLOAD: begin
                    busy      = 1'b1;
                    out_valid = 1'b1;
                    out_data  = mem[ocnt];
                    if (out_ready && ocnt == idx_t'(P - 1)) state_n = LOAD;
                end
                default: state_n = LOAD;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            ocnt     <= '0;
            b        <= '0;
            s        <= '0;
            ovf_flag <= 1'b0;
        end else begin
            if (ld_fire) begin
                cnt <= cnt + 1'b1;
                if (cnt == '0) ovf_flag <= 1'b0;
            end
            if (cmp_en) begin
                ovf_flag <= ovf_flag | mac_ovf;
                b        <= last_b ? '0 : b + 1'b1;
                if (last_b) s <= last_s ? '0 : s + 1'b1;
            end
            if (out_fire) ocnt <= ocnt + 1'b1;
        end
    end

    // Buffer has no reset; in-place butterfly write-back.
    always_ff @(posedge clk) begin
        if (ld_fire) mem[bitrev(cnt)] <= in_data;
        if (cmp_en) begin
            mem[top] <= mac_add;
            mem[bot] <= mac_sub;
        end
    end
endmodule

// File: tb/tb_fft_butterfly_sched.sv
// tb_fft_butterfly_sched: directed and random frames checked against a
// stage-by-stage FFT model, with a bench-side sign-magnitude MAC.
module tb_fft_butterfly_sched;
    localparam int N  = 8;
    localparam int Q  = 6;
    localparam int P  = 8;
    localparam int NB = 12;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [2*N-1:0] in_data;
    logic [2*N-1:0] mac_in1, mac_in2, mac_in3;
    logic [2*N-1:0] mac_add, mac_sub;
    logic           mac_ovf;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] out_data;
    logic           ovf_flag;
    logic           busy;

    always #5 clk = ~clk;

    fft_butterfly_sched #(.N(N), .Q(Q), .LOGP(3)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .mac_in1(mac_in1), .mac_in2(mac_in2), .mac_in3(mac_in3),
        .mac_add(mac_add), .mac_sub(mac_sub), .mac_ovf(mac_ovf),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .ovf_flag(ovf_flag), .busy(busy)
    );

    int checks = 0;
    int errors = 0;
    logic [2*N-1:0] wt [4] = '{16'h4000, 16'h2DAD, 16'h00C0, 16'hADAD};
    logic [2*N-1:0] frame [P];
    logic [2*N-1:0] got [P];
    logic [2*N-1:0] refm [P];
    int st_top [NB];
    int st_bot [NB];
    int st_k [NB];
    bit force_ovf;
    bit prev_ovf;
    logic [4*N:0] env;

    function automatic int dec(logic [N-1:0] v);
        int m;
        m = int'(v[N-2:0]);
        return v[N-1] ? -m : m;
    endfunction

    function automatic logic [N:0] enc(int x);
        int m;
        m = (1 << (N-1)) - 1;
        if (x > m) return {2'b10, (N-1)'(m)};
        if (x < -m) return {2'b11, (N-1)'(m)};
        if (x < 0) return {2'b01, (N-1)'(-x)};
        return {2'b00, (N-1)'(x)};
    endfunction

    // {ovf, add, sub} for add = a + c*w, sub = a - c*w, saturating.
    function automatic logic [4*N:0] mac(logic [2*N-1:0] a,
                                         logic [2*N-1:0] c,
                                         logic [2*N-1:0] w);
        int pr, pim;
        logic [N:0] ar, ai, sr, si;
        pr  = (dec(c[2*N-1:N]) * dec(w[2*N-1:N])
             - dec(c[N-1:0]) * dec(w[N-1:0])) / (1 << Q);
        pim = (dec(c[2*N-1:N]) * dec(w[N-1:0])
             + dec(c[N-1:0]) * dec(w[2*N-1:N])) / (1 << Q);
        ar = enc(dec(a[2*N-1:N]) + pr);
        ai = enc(dec(a[N-1:0]) + pim);
        sr = enc(dec(a[2*N-1:N]) - pr);
        si = enc(dec(a[N-1:0]) - pim);
        return {ar[N] | ai[N] | sr[N] | si[N],
                ar[N-1:0], ai[N-1:0], sr[N-1:0], si[N-1:0]};
    endfunction

    always_comb begin
        env     = mac(mac_in1, mac_in2, mac_in3);
        mac_add = env[4*N-1:2*N];
        mac_sub = env[2*N-1:0];
        mac_ovf = env[4*N] | force_ovf;
    end

    function automatic int brev(int i);
        int r;
        r = 0;
        for (int k = 0; k < 3; k++)
            if ((i & (1 << k)) != 0) r |= 1 << (2 - k);
        return r;
    endfunction

    function automatic logic [N-1:0] rc();
        logic sg;
        sg = 1'($urandom_range(0, 1));
        return {sg, 7'($urandom_range(0, 40))};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic chk_rst_out();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mac_in1", mac_in1, 0);
        chk("rst_mac_in2", mac_in2, 0);
        chk("rst_mac_in3", mac_in3, 0);
        chk("rst_out_data", out_data, 0);
    endtask

    // mode: 0 ready always, 1 ready 1,0,0,1 pattern, 2 random ready
    task automatic run_frame(input int mode, input int ovf_at,
                             input int rst_at, input bit load_ovf,
                             input bit gaps);
        int i, guard, hs, cyc;
        bit v, rdy, acc;
        logic [4*N:0] r;
        i = 0;
        guard = 0;
        while (i < P && guard < 100) begin
            @(negedge clk);
            guard++;
            force_ovf = load_ovf && i > 0;
            chk("load_in_ready", in_ready, 1);
            chk("load_busy", busy, 0);
            chk("load_out_valid", out_valid, 0);
            if (i == 0) chk("ovf_hold", ovf_flag, prev_ovf);
            else        chk("ovf_cleared", ovf_flag, 0);
            v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_valid = v;
            in_data  = frame[i];
            if (v && in_ready) i++;
        end
        if (i < P) begin
            chk("load_timeout", i, P);
            in_valid = 0;
            return;
        end
        for (int j = 0; j < P; j++) refm[brev(j)] = frame[j];
        acc = 0;
        for (int st = 0; st < NB; st++) begin
            @(negedge clk);
            in_valid  = 0;
            force_ovf = 0;
            chk("cmp_busy", busy, 1);
            chk("cmp_in_ready", in_ready, 0);
            chk("cmp_out_valid", out_valid, 0);
            chk("cmp_in1", mac_in1, refm[st_top[st]]);
            chk("cmp_in2", mac_in2, refm[st_bot[st]]);
            chk("cmp_in3", mac_in3, wt[st_k[st]]);
            chk("cmp_ovf", ovf_flag, acc);
            if (st == rst_at) begin
                rst = 1;
                @(negedge clk);
                chk_rst_out();
                rst = 0;
                @(negedge clk);
                chk("abort_in_ready", in_ready, 1);
                chk("abort_out_valid", out_valid, 0);
                chk("abort_ovf", ovf_flag, 0);
                prev_ovf = 0;
                return;
            end
            r = mac(refm[st_top[st]], refm[st_bot[st]], wt[st_k[st]]);
            refm[st_top[st]] = r[4*N-1:2*N];
            refm[st_bot[st]] = r[2*N-1:0];
            acc = acc | r[4*N];
            if (st == ovf_at) begin
                force_ovf = 1;
                acc = 1;
            end
        end
        hs = 0;
        cyc = 0;
        while (hs < P && cyc < 100) begin
            @(negedge clk);
            force_ovf = 0;
            chk("unl_out_valid", out_valid, 1);
            chk("unl_busy", busy, 1);
            chk("unl_in_ready", in_ready, 0);
            chk("unl_data", out_data, refm[hs]);
            chk("unl_ovf", ovf_flag, acc);
            case (mode)
                0:       rdy = 1;
                1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            if (rdy) begin
                got[hs] = out_data;
                hs++;
            end
            cyc++;
        end
        if (hs < P) chk("unload_timeout", hs, P);
        @(negedge clk);
        out_ready = 0;
        chk("post_out_valid", out_valid, 0);
        chk("post_busy", busy, 0);
        chk("post_in_ready", in_ready, 1);
        chk("post_ovf", ovf_flag, acc);
        prev_ovf = acc;
    endtask

    initial begin
        int n;
        n = 0;
        for (int s = 0; s < 3; s++)
            for (int g = 0; g < P; g += (2 << s))
                for (int j = 0; j < (1 << s); j++) begin
                    st_top[n] = g + j;
                    st_bot[n] = g + j + (1 << s);
                    st_k[n]   = j * (4 >> s);
                    n++;
                end
        rst = 1;
        in_valid = 0;
        in_data = '0;
        out_ready = 0;
        force_ovf = 0;
        prev_ovf = 0;
        repeat (2) @(negedge clk);
        chk_rst_out();
        rst = 0;
        @(negedge clk);
        chk("init_in_ready", in_ready, 1);
        chk("init_ovf", ovf_flag, 0);

        frame = '{default: '0};
        frame[0] = 16'h4000;
        run_frame(0, -1, -1, 1'b0, 1'b0);
        for (int i = 0; i < P; i++) chk("impulse_x", got[i], 16'h4000);
        chk("impulse_ovf", ovf_flag, 0);

        frame = '{default: 16'h0800};
        run_frame(0, -1, -1, 1'b1, 1'b0);
        chk("dc_x0", got[0], 16'h4000);
        for (int i = 1; i < P; i++) chk("dc_zero", got[i] & 16'h7F7F, 0);
        chk("dc_ovf", ovf_flag, 0);

        frame = '{default: '0};
        frame[1] = 16'h4000;
        run_frame(0, 5, -1, 1'b0, 1'b0);
        chk("ovf_sticky", ovf_flag, 1);

        for (int i = 0; i < P; i++) frame[i] = {rc(), rc()};
        run_frame(1, -1, -1, 1'b0, 1'b0);

        frame = '{default: '0};
        frame[1] = 16'h4000;
        run_frame(0, -1, 4, 1'b0, 1'b0);

        frame = '{default: '0};
        frame[0] = 16'h4000;
        run_frame(0, -1, -1, 1'b0, 1'b0);
        for (int i = 0; i < P; i++) chk("reimpulse_x", got[i], 16'h4000);

        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < P; i++) frame[i] = {rc(), rc()};
            run_frame(2, -1, -1, 1'b0, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
